// File: rtl/track_sequencer.sv
// track_sequencer
//
// Runs one tracking iteration per camera frame. It freezes the static frame
// buffer for exactly one whole frame, starts the correlator over the current
// search window, and then re-centres that window on the best match.
//
// Ports
//   GCLK, reset        clock; synchronous active-high reset
//   track_en           level, user tracking toggle; dropping it aborts to IDLE
//   template_rdy       level, template register is frozen and valid
//   frame_done         one-cycle pulse at the last captured pixel (GCLK domain)
//   static_we          write-enable gate for the static frame BRAM
//   corr_start         one-cycle pulse starting the correlator
//   corr_done          one-cycle pulse; corr_max_x/_y/corr_score valid with it
//   corr_max_x/_y      top-left of the best match
//   corr_score         best-match score, higher is better
//   win_left/right/top/bottom  search window (inclusive template positions)
//   track_x/_y         last accepted match position
//   locked             a valid match is currently held
//   timeout_err        sticky: correlator did not answer within TIMEOUT cycles
//   state_dbg          current FSM state (IDLE=0 ARM=1 CAPTURE=2 CORRELATE=3 UPDATE=4)
//
// Correlator handshake: corr_start is a single-cycle request issued once per
// CORRELATE visit; the first corr_done seen while still in CORRELATE is the
// answer and its data is captured in that same cycle. corr_done in any other
// state is ignored, and no answer within TIMEOUT cycles abandons the run.

module track_sequencer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          TW         = 32,
    parameter int          RADIUS     = 48,
    parameter logic [19:0] MIN_SCORE  = 20'd4096,
    parameter int          MISS_LIMIT = 3,
    parameter logic [23:0] TIMEOUT    = 24'd4_000_000
) (
    input  logic        GCLK,
    input  logic        reset,
    input  logic        track_en,
    input  logic        template_rdy,
    input  logic        frame_done,
    output logic        static_we,
    output logic        corr_start,
    input  logic        corr_done,
    input  logic [9:0]  corr_max_x,
    input  logic [9:0]  corr_max_y,
    input  logic [19:0] corr_score,
    output logic [9:0]  win_left,
    output logic [9:0]  win_right,
    output logic [9:0]  win_top,
    output logic [9:0]  win_bottom,
    output logic [9:0]  track_x,
    output logic [9:0]  track_y,
    output logic        locked,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        CAPTURE   = 3'd2,
        CORRELATE = 3'd3,
        UPDATE    = 3'd4
    } state_t;

    localparam logic [9:0] X_MAX    = 10'(H_RES - TW);
    localparam logic [9:0] Y_MAX    = 10'(V_RES - TW);
    localparam logic [7:0] MISS_TOP = 8'(MISS_LIMIT);

    state_t       state;
    logic [23:0]  tmo_cnt;
    logic [7:0]   miss_cnt;
    logic [9:0]   max_x_q;
    logic [9:0]   max_y_q;
    logic [19:0]  score_q;

    assign state_dbg = state;

    // Lower window edge: max(0, p - RADIUS). Signed arithmetic carries one bit
    // of headroom so that out-of-range correlator coordinates cannot wrap.
    function automatic logic [9:0] lo_clip(input logic [9:0] p);
        logic signed [11:0] v;
        v = $signed({2'b00, p}) - $signed(12'(RADIUS));
        return (v < 12'sd0) ? 10'd0 : v[9:0];
    endfunction

    // Upper window edge: min(lim, p + RADIUS).
    function automatic logic [9:0] hi_clip(input logic [9:0] p, input logic [9:0] lim);
        logic signed [11:0] v;
        v = $signed({2'b00, p}) + $signed(12'(RADIUS));
        return (v > $signed({2'b00, lim})) ? lim : v[9:0];
    endfunction

    always_ff @(posedge GCLK) begin
        if (reset) begin
            state       <= IDLE;
            static_we   <= 1'b0;
            corr_start  <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            track_x     <= 10'd0;
            track_y     <= 10'd0;
            miss_cnt    <= 8'd0;
            tmo_cnt     <= 24'd0;
            max_x_q     <= 10'd0;
            max_y_q     <= 10'd0;
            score_q     <= 20'd0;
            win_left    <= 10'd0;
            win_right   <= X_MAX;
            win_top     <= 10'd0;
            win_bottom  <= Y_MAX;
        end else begin
            corr_start <= 1'b0;

            // Dropping track_en overrides whatever else happens this cycle,
            // including a coincident frame_done or corr_done.
            if (state != IDLE && !track_en) begin
                state      <= IDLE;
                static_we  <= 1'b0;
                locked     <= 1'b0;
                miss_cnt   <= 8'd0;
                win_left   <= 10'd0;
                win_right  <= X_MAX;
                win_top    <= 10'd0;
                win_bottom <= Y_MAX;
            end else begin
                case (state)
                    IDLE: begin
                        static_we  <= 1'b0;
                        locked     <= 1'b0;
                        win_left   <= 10'd0;
                        win_right  <= X_MAX;
                        win_top    <= 10'd0;
                        win_bottom <= Y_MAX;
                        if (track_en && template_rdy) begin
                            state       <= ARM;
                            timeout_err <= 1'b0;
                            miss_cnt    <= 8'd0;
                        end
                    end

                    // Wait for a frame boundary so the BRAM write covers whole frames.
                    ARM: begin
                        if (frame_done) begin
                            state     <= CAPTURE;
                            static_we <= 1'b1;
                        end
                    end

                    CAPTURE: begin
                        if (frame_done) begin
                            state     <= CORRELATE;
                            static_we <= 1'b0;
                            tmo_cnt   <= 24'd0;
                        end
                    end

                    // tmo_cnt == 0 marks the first cycle of the visit.
                    CORRELATE: begin
                        if (tmo_cnt == 24'd0) begin
                            corr_start <= 1'b1;
                        end
                        if (corr_done) begin
                            max_x_q <= corr_max_x;
                            max_y_q <= corr_max_y;
                            score_q <= corr_score;
                            state   <= UPDATE;
                        end else if (tmo_cnt == TIMEOUT) begin
                            timeout_err <= 1'b1;
                            locked      <= 1'b0;
                            win_left    <= 10'd0;
                            win_right   <= X_MAX;
                            win_top     <= 10'd0;
                            win_bottom  <= Y_MAX;
                            state       <= ARM;
                        end else begin
                            tmo_cnt <= tmo_cnt + 24'd1;
                        end
                    end

                    UPDATE: begin
                        state <= ARM;
                        if (score_q >= MIN_SCORE) begin
                            track_x    <= max_x_q;
                            track_y    <= max_y_q;
                            locked     <= 1'b1;
                            miss_cnt   <= 8'd0;
                            win_left   <= lo_clip(max_x_q);
                            win_right  <= hi_clip(max_x_q, X_MAX);
                            win_top    <= lo_clip(max_y_q);
                            win_bottom <= hi_clip(max_y_q, Y_MAX);
                        end else if (miss_cnt + 8'd1 >= MISS_TOP) begin
                            // Lock lost: search the whole frame again, keep last position.
                            miss_cnt   <= MISS_TOP;
                            locked     <= 1'b0;
                            win_left   <= 10'd0;
                            win_right  <= X_MAX;
                            win_top    <= 10'd0;
                            win_bottom <= Y_MAX;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer: walks start-up, hits at both corners,
// a miss run, a correlator timeout, a stray corr_done, an abort and a
// mid-frame reset. Expected values are hand-computed constants.

module tb_track_sequencer;

    localparam int          G   = 100;       // frame period in GCLK cycles
    localparam logic [23:0] TMO = 24'd200;   // shortened correlator timeout

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_CORR = 3'd3;

    logic        GCLK;
    logic        reset;
    logic        track_en;
    logic        template_rdy;
    logic        frame_done;
    logic        static_we;
    logic        corr_start;
    logic        corr_done;
    logic [9:0]  corr_max_x;
    logic [9:0]  corr_max_y;
    logic [19:0] corr_score;
    logic [9:0]  win_left, win_right, win_top, win_bottom;
    logic [9:0]  track_x, track_y;
    logic        locked;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q[$];

    int cyc = 0;
    int we_total = 0;
    int start_total = 0;
    int start_cyc = 0;
    int fd_cyc = 0;

    track_sequencer #(.TIMEOUT(TMO)) dut (
        .GCLK        (GCLK),
        .reset       (reset),
        .track_en    (track_en),
        .template_rdy(template_rdy),
        .frame_done  (frame_done),
        .static_we   (static_we),
        .corr_start  (corr_start),
        .corr_done   (corr_done),
        .corr_max_x  (corr_max_x),
        .corr_max_y  (corr_max_y),
        .corr_score  (corr_score),
        .win_left    (win_left),
        .win_right   (win_right),
        .win_top     (win_top),
        .win_bottom  (win_bottom),
        .track_x     (track_x),
        .track_y     (track_y),
        .locked      (locked),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    always @(posedge GCLK) cyc <= cyc + 1;

    // Mid-cycle monitor: enable cycles, start pulses and their timing.
    always @(negedge GCLK) begin
        if (static_we)  we_total <= we_total + 1;
        if (corr_start) begin
            start_total <= start_total + 1;
            start_cyc   <= cyc;
        end
        if (frame_done) fd_cyc <= cyc;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_win(input logic [9:0] l, input logic [9:0] r,
                            input logic [9:0] t, input logic [9:0] b);
        exp_q.push_back({l, r, t, b});
    endtask

    task automatic check_win(input string tag);
        logic [39:0] e;
        e = exp_q.pop_front();
        check(tag, {24'd0, win_left, win_right, win_top, win_bottom}, {24'd0, e});
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_pulse();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic corr_pulse(input logic [9:0] x, input logic [9:0] y, input logic [19:0] s);
        corr_max_x = x;
        corr_max_y = y;
        corr_score = s;
        corr_done  = 1'b1;
        tick();
        corr_done  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!corr_start && n < 20) begin
            tick();
            n++;
        end
        check(tag, {63'd0, corr_start}, 64'd1);
    endtask

    // One full iteration up to the UPDATE cycle; caller checks the new window.
    task automatic iterate(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [19:0] s);
        frame_pulse();
        idle(G - 1);
        frame_pulse();
        wait_start(tag);
        idle(2);
        corr_pulse(x, y, s);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int we_base, st_base, n;

        reset        = 1'b1;
        track_en     = 1'b0;
        template_rdy = 1'b0;
        frame_done   = 1'b0;
        corr_done    = 1'b0;
        corr_max_x   = 10'd0;
        corr_max_y   = 10'd0;
        corr_score   = 20'd0;
        idle(3);

        // Reset values
        check("rst_state", {61'd0, state_dbg}, {61'd0, S_IDLE});
        check("rst_we", {63'd0, static_we}, 64'd0);
        check("rst_start", {63'd0, corr_start}, 64'd0);
        check("rst_locked", {63'd0, locked}, 64'd0);
        check("rst_tmo", {63'd0, timeout_err}, 64'd0);
        check("rst_track", {44'd0, track_x, track_y}, 64'd0);
        push_win(10'd0, 10'd608, 10'd0, 10'd448);
        check_win("rst_win");

        // Start-up
        reset        = 1'b0;
        track_en     = 1'b1;
        template_rdy = 1'b1;
        tick();
        check("arm_state", {61'd0, state_dbg}, {61'd0, S_ARM});
        we_base = we_total;
        st_base = start_total;
        frame_pulse();
        check("we_latency", {63'd0, static_we}, 64'd1);
        idle(G - 1);
        frame_pulse();
        check("we_drop", {63'd0, static_we}, 64'd0);
        wait_start("start_seen");
        idle(1);
        check("we_cycles", 64'(we_total - we_base), 64'(G));
        check("start_once", 64'(start_total - st_base), 64'd1);
        check("start_latency", 64'(start_cyc - fd_cyc), 64'd2);
        check("corr_state", {61'd0, state_dbg}, {61'd0, S_CORR});

        // Hit near corner, including corr_done -> window latency of 2
        idle(1);
        corr_pulse(10'd10, 10'd20, 20'd5000);
        push_win(10'd0, 10'd608, 10'd0, 10'd448);
        check_win("win_hold_update");
        tick();
        push_win(10'd0, 10'd58, 10'd0, 10'd68);
        check_win("win_corner");
        check("track_corner", {44'd0, track_x, track_y}, {44'd0, 10'd10, 10'd20});
        check("lock_corner", {63'd0, locked}, 64'd1);
        check("arm_after_upd", {61'd0, state_dbg}, {61'd0, S_ARM});

        // Hit near far edge
        iterate("start_far", 10'd600, 10'd440, 20'd5000);
        push_win(10'd552, 10'd608, 10'd392, 10'd448);
        check_win("win_far");
        check("track_far", {44'd0, track_x, track_y}, {44'd0, 10'd600, 10'd440});

        // Three misses drop the lock on the third
        iterate("start_miss1", 10'd5, 10'd5, 20'd100);
        check("lock_miss1", {63'd0, locked}, 64'd1);
        push_win(10'd552, 10'd608, 10'd392, 10'd448);
        check_win("win_miss1");
        iterate("start_miss2", 10'd5, 10'd5, 20'd100);
        check("lock_miss2", {63'd0, locked}, 64'd1);
        iterate("start_miss3", 10'd5, 10'd5, 20'd100);
        check("lock_miss3", {63'd0, locked}, 64'd0);
        push_win(10'd0, 10'd608, 10'd0, 10'd448);
        check_win("win_miss3");
        check("track_miss3", {44'd0, track_x, track_y}, {44'd0, 10'd600, 10'd440});

        // Score exactly at threshold is a hit
        iterate("start_thr", 10'd300, 10'd200, 20'd4096);
        push_win(10'd252, 10'd348, 10'd152, 10'd248);
        check_win("win_thr");
        check("lock_thr", {63'd0, locked}, 64'd1);

        // Timeout: corr_start seen, then no answer
        frame_pulse();
        idle(G - 1);
        frame_pulse();
        wait_start("start_tmo");
        n = 0;
        while (!timeout_err && n < int'(TMO) + 20) begin
            tick();
            n++;
        end
        check("tmo_latency", 64'(n), 64'(TMO));
        check("tmo_state", {61'd0, state_dbg}, {61'd0, S_ARM});
        check("tmo_lock", {63'd0, locked}, 64'd0);
        push_win(10'd0, 10'd608, 10'd0, 10'd448);
        check_win("win_tmo");

        // Next iteration proceeds normally; the error stays sticky
        iterate("start_after_tmo", 10'd100, 10'd100, 20'd9000);
        push_win(10'd52, 10'd148, 10'd52, 10'd148);
        check_win("win_after_tmo");
        check("tmo_sticky", {63'd0, timeout_err}, 64'd1);

        // Stray corr_done in ARM is ignored
        corr_pulse(10'd7, 10'd7, 20'd9000);
        idle(2);
        check("stray_track", {44'd0, track_x, track_y}, {44'd0, 10'd100, 10'd100});
        check("stray_state", {61'd0, state_dbg}, {61'd0, S_ARM});

        // Abort: track_en drops together with corr_done
        frame_pulse();
        idle(G - 1);
        frame_pulse();
        wait_start("start_abort");
        idle(1);
        track_en = 1'b0;
        corr_pulse(10'd300, 10'd300, 20'd9000);
        check("abort_state", {61'd0, state_dbg}, {61'd0, S_IDLE});
        check("abort_we", {63'd0, static_we}, 64'd0);
        check("abort_track", {44'd0, track_x, track_y}, {44'd0, 10'd100, 10'd100});
        check("abort_lock", {63'd0, locked}, 64'd0);
        st_base = start_total;
        frame_pulse();
        idle(G - 1);
        frame_pulse();
        idle(5);
        check("abort_no_start", 64'(start_total - st_base), 64'd0);
        check("abort_we_low", {63'd0, static_we}, 64'd0);

        // Re-arm clears the sticky error
        track_en = 1'b1;
        tick();
        check("rearm_state", {61'd0, state_dbg}, {61'd0, S_ARM});
        check("rearm_tmo_clr", {63'd0, timeout_err}, 64'd0);

        // Reset mid-frame stops the BRAM write on the next edge
        frame_pulse();
        idle(10);
        check("capture_we", {63'd0, static_we}, 64'd1);
        reset = 1'b1;
        tick();
        check("midrst_we", {63'd0, static_we}, 64'd0);
        check("midrst_state", {61'd0, state_dbg}, {61'd0, S_IDLE});
        check("midrst_track", {44'd0, track_x, track_y}, 64'd0);
        push_win(10'd0, 10'd608, 10'd0, 10'd448);
        check_win("midrst_win");
        reset = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
